// File: rtl/counter_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_seq_ctrl_pkg : state encoding and pulse constants shared by   |
// |                        the counter command sequencer                  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package counter_seq_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      LOAD = ST_LOAD,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Length in cycles of the done/aborted status pulses.
   localparam int unsigned PULSE_CYCLES = 1;
   localparam int unsigned PULSE_CNT_W  = $clog2(PULSE_CYCLES + 1);

endpackage
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_seq_ctrl : accepts (start, end) run commands and drives the   |
// |                    downstream counter until cnt_out reaches end       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int RUNS_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [WIDTH-1:0]  cmd_start,
   input  logic [WIDTH-1:0]  cmd_end,
   input  logic              abort,
   input  logic [WIDTH-1:0]  cnt_out,
   output logic              load,
   output logic              enab,
   output logic [WIDTH-1:0]  cnt_in,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [RUNS_W-1:0] runs
);

   localparam logic [RUNS_W-1:0]      RUNS_ONE   = RUNS_W'(1);
   localparam logic [PULSE_CNT_W-1:0] ABORT_LEN  = PULSE_CNT_W'(PULSE_CYCLES);
   localparam logic [PULSE_CNT_W-1:0] ABORT_STEP = PULSE_CNT_W'(1);

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       start_q, start_d;
   logic [WIDTH-1:0]       end_q, end_d;
   logic [RUNS_W-1:0]      runs_q, runs_d;
   logic [PULSE_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
   logic                   at_end;

   assign at_end = (cnt_out == end_q);

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      end_d       = end_q;
      runs_d      = runs_q;
      abort_cnt_d = (abort_cnt_q != '0) ? abort_cnt_q - ABORT_STEP : '0;
      cmd_ready   = 1'b0;
      load        = 1'b0;
      enab        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = LOAD;
               start_d = cmd_start;
               end_d   = cmd_end;
            end
         end
         LOAD: begin
            load = 1'b1;
            enab = 1'b1;
            if (abort) begin
               state_d     = IDLE;
               abort_cnt_d = ABORT_LEN;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Holding enab low on the terminal value clears the counter next cycle.
            enab = !at_end;
            if (abort) begin
               state_d     = IDLE;
               abort_cnt_d = ABORT_LEN;
            end else if (at_end) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
            if (runs_q != '1) begin
               runs_d = runs_q + RUNS_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         start_q     <= '0;
         end_q       <= '0;
         runs_q      <= '0;
         abort_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         end_q       <= end_d;
         runs_q      <= runs_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign aborted = (abort_cnt_q != '0);
   assign cnt_in  = start_q;
   assign runs    = runs_q;

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Command sequencer directly upstream of the team's loadable `counter`. It accepts a run command (start value, end value) over a valid/ready handshake and drives the counter's `load`/`enab`/`cnt_in`. It watches `cnt_out` until it equals the end value, then signals completion. It is the only driver of the counter's control inputs.

## Interface
- `WIDTH`, 5, count width; must match the downstream counter.
- `RUNS_W`, 8, width of the completed-run counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_start` input WIDTH: value to load into the counter.
- `cmd_end` input WIDTH: terminal value.
- `abort` input 1: cancel the current run.
- `cnt_out` input WIDTH: counter output (feedback).
- `load` output 1: to counter.
- `enab` output 1: to counter.
- `cnt_in` output WIDTH: to counter.
- `busy` output 1: a run is in progress (not IDLE).
- `done` output 1: one-cycle pulse when a run completes.
- `aborted` output 1: one-cycle pulse when a run is cancelled.
- `runs` output RUNS_W: count of completed runs; saturates at all-ones.

## Operation
- States:
  - IDLE: `cmd_ready=1`, `load=0`, `enab=0`.
  - LOAD: `load=1`, `enab=1`, `cnt_in=start_q`.
  - RUN: `load=0`, `enab = (cnt_out != end_q)`.
  - DONE: `done=1`, `enab=0`.
- Outputs are decoded from the state. `enab` in RUN is Mealy on `cnt_out`.
- Transitions:
  - IDLE→LOAD on `cmd_valid & cmd_ready`. `start_q`/`end_q` capture `cmd_start`/`cmd_end` in the same cycle.
  - LOAD→RUN unconditionally.
  - RUN→DONE when `cnt_out == end_q`.
  - DONE→IDLE unconditionally; `runs` increments on this transition unless already saturated.
- `abort` in LOAD or RUN:
  - next state IDLE, `aborted=1` for exactly that next cycle;
  - no `done` pulse, `runs` unchanged.
- `abort` in IDLE or DONE: ignored. DONE always completes.
- Wrap-around: the counter counts modulo 2^WIDTH. If `cmd_end < cmd_start`, the run wraps through 0, which is legal.
- RUN length: N = ((end − start) mod 2^WIDTH) + 1 cycles. `start == end` gives N = 1.
- A command is never accepted outside IDLE. `cmd_valid` held high while busy waits; it is accepted in the first IDLE cycle.
- Dropping `enab` clears the downstream counter. A `cnt_out` of 0 after DONE or abort is expected and not an error.
- `cnt_in` holds `start_q` in all states (stable; no X).

## Timing
- Cycle 0: handshake. Cycle 1: LOAD. Cycles 2 … 1+N: RUN, with `cnt_out` = start … end. Cycle 2+N: DONE. Cycle 3+N: IDLE, `cmd_ready=1`.
- Minimum command-to-command spacing is N+3 cycles.
- Reset values: state IDLE, `cmd_ready=1`, `load=0`, `enab=0`, `busy=0`, `done=0`, `aborted=0`, `runs=0`, `start_q=0`, `end_q=0`, `cnt_in=0`.
- `rst` mid-run: IDLE next cycle with no `done`/`aborted` pulse and `runs` cleared. `rst` has priority over `abort` and over the handshake.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the `done`/`aborted` pulse-width constant (1).
- Single module: a two-process FSM plus command and run-count registers. No sub-module.
- The bench instantiates the existing `counter` downstream and connects `cnt_out` back.

## Test plan
- Basic run, WIDTH=5:
  - Stimulus: start=3, end=7 accepted at cycle 0.
  - Required: `load` high in cycle 1; `cnt_out` 3,4,5,6,7 in cycles 2–6; `done` in cycle 7; `runs`=1; `cmd_ready` high in cycle 8.
- Wrap run:
  - Stimulus: start=30, end=1.
  - Required: `cnt_out` 30,31,0,1; N=4; `done` at cycle 6.
- Single-value run:
  - Stimulus: start=end=9.
  - Required: one RUN cycle with `enab=0`; `done` at cycle 3.
- Abort:
  - Stimulus: `abort` asserted in the RUN cycle where `cnt_out`=5 (start=3, end=20).
  - Required: `aborted` pulse next cycle, no `done`, `runs` unchanged, `cmd_ready=1`.
- Back-to-back and saturation:
  - Stimulus: `cmd_valid` held high with RUNS_W=2.
  - Required: commands accepted only in IDLE; `runs` stops at 3 after the 4th completion.
- Reset mid-run:
  - Stimulus: `rst` in RUN.
  - Required: all outputs at reset values the next cycle; `runs`=0.
